// File: rtl/fifo_frame_reader_if.sv
// Bundle of the FIFO show-ahead read port, the framed output stream and the
// status signals of the frame reader.
interface fifo_frame_reader_if #(
    parameter int DWIDTH  = 32,
    parameter int FCWIDTH = 16
);
    logic               enable;
    logic               fifo_empty;
    logic [DWIDTH-1:0]  fifo_data;
    logic               fifo_rd_en;
    logic               m_valid;
    logic               m_ready;
    logic [DWIDTH-1:0]  m_data;
    logic               m_last;
    logic [FCWIDTH-1:0] frame_cnt;
    logic               busy;

    modport master (
        input  enable, fifo_empty, fifo_data, m_ready,
        output fifo_rd_en, m_valid, m_data, m_last, frame_cnt, busy
    );

    modport slave (
        output enable, fifo_empty, fifo_data, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_last, frame_cnt, busy
    );
endinterface

// File: rtl/fifo_frame_reader.sv
// Drains a show-ahead FIFO into a valid/ready stream cut into fixed-length
// frames, with a 2-entry skid buffer and a clean frame close on disable.
module fifo_frame_reader #(
    parameter int DWIDTH    = 32,
    parameter int FRAME_LEN = 8,
    parameter int IWIDTH    = 8,
    parameter int FCWIDTH   = 16
) (
    input  logic               clock,
    input  logic               reset,
    fifo_frame_reader_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [IWIDTH-1:0] LAST_IDX = IWIDTH'(FRAME_LEN - 1);

    state_t             state_q, state_d;
    logic [1:0]         occ_q, occ_d;
    logic [IWIDTH-1:0]  idx_q, idx_d;
    logic [DWIDTH-1:0]  data0_q, data0_d, data1_q, data1_d;
    logic               last0_q, last0_d, last1_q, last1_d;
    logic [FCWIDTH-1:0] cnt_q, cnt_d;

    logic pop_fifo;
    logic pop_last;
    logic out_hs;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Leaving RUN looks at the index after this edge's pop, so a pop that
    // opens or closes a frame in the same cycle is accounted for.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.enable) state_d = RUN;
            RUN:     if (!bus.enable) state_d = (idx_d == '0) ? IDLE : DRAIN;
            DRAIN:   if (pop_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop_fifo = 1'b0;
        if ((state_q == RUN || state_q == DRAIN) && !bus.fifo_empty && occ_q != 2'd2) begin
            pop_fifo = 1'b1;
        end
    end

    assign pop_last       = pop_fifo && (idx_q == LAST_IDX);
    assign out_hs         = bus.m_valid && bus.m_ready;
    assign bus.fifo_rd_en = pop_fifo;
    assign bus.m_valid    = (occ_q != 2'd0);
    assign bus.m_data     = data0_q;
    assign bus.m_last     = last0_q;
    assign bus.frame_cnt  = cnt_q;
    assign bus.busy       = (state_q != IDLE) || (occ_q != 2'd0);

    always_comb begin
        idx_d = idx_q;
        if (pop_fifo) begin
            idx_d = pop_last ? '0 : idx_q + 1'b1;
        end
    end

    // Entry 0 is always the head; a push lands in the first free slot after
    // any head removal in the same cycle.
    always_comb begin
        occ_d   = occ_q;
        data0_d = data0_q;
        data1_d = data1_q;
        last0_d = last0_q;
        last1_d = last1_q;
        unique case (occ_q)
            2'd0: begin
                if (pop_fifo) begin
                    data0_d = bus.fifo_data;
                    last0_d = pop_last;
                    occ_d   = 2'd1;
                end
            end
            2'd1: begin
                if (pop_fifo && out_hs) begin
                    data0_d = bus.fifo_data;
                    last0_d = pop_last;
                end else if (pop_fifo) begin
                    data1_d = bus.fifo_data;
                    last1_d = pop_last;
                    occ_d   = 2'd2;
                end else if (out_hs) begin
                    occ_d   = 2'd0;
                end
            end
            default: begin
                if (out_hs) begin
                    data0_d = data1_q;
                    last0_d = last1_q;
                    occ_d   = 2'd1;
                end
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (out_hs && last0_q) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            occ_q   <= 2'd0;
            idx_q   <= '0;
            data0_q <= '0;
            data1_q <= '0;
            last0_q <= 1'b0;
            last1_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            occ_q   <= occ_d;
            idx_q   <= idx_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
            last0_q <= last0_d;
            last1_q <= last1_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_fifo_frame_reader.sv
// Bench for fifo_frame_reader: instance A (FRAME_LEN=4) for streaming,
// back-pressure, disable, underrun and reset; instance B for counter wrap.
module tb_fifo_frame_reader;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    fifo_frame_reader_if #(.DWIDTH(32), .FCWIDTH(16)) ifa ();
    fifo_frame_reader_if #(.DWIDTH(32), .FCWIDTH(2))  ifb ();

    fifo_frame_reader #(.DWIDTH(32), .FRAME_LEN(4), .IWIDTH(8), .FCWIDTH(16)) dut_a (
        .clock(clock), .reset(reset), .bus(ifa.master));
    fifo_frame_reader #(.DWIDTH(32), .FRAME_LEN(1), .IWIDTH(8), .FCWIDTH(2)) dut_b (
        .clock(clock), .reset(reset), .bus(ifb.master));

    // Show-ahead FIFO models; reset flushes unread contents.
    logic [31:0] mem_a [0:63];
    logic [31:0] mem_b [0:63];
    logic [7:0]  wr_a = '0, rd_a = '0, wr_b = '0, rd_b = '0;
    int          pops_a = 0;

    assign ifa.fifo_empty = (wr_a == rd_a);
    assign ifa.fifo_data  = mem_a[rd_a[5:0]];
    assign ifb.fifo_empty = (wr_b == rd_b);
    assign ifb.fifo_data  = mem_b[rd_b[5:0]];

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_a <= wr_a;
            rd_b <= wr_b;
        end else begin
            if (ifa.fifo_rd_en) begin
                rd_a   <= rd_a + 8'd1;
                pops_a <= pops_a + 1;
            end
            if (ifb.fifo_rd_en) rd_b <= rd_b + 8'd1;
        end
    end

    int total = 0;
    int bad = 0;
    logic [32:0] exp_a [$];
    logic [32:0] exp_b [$];
    int tag_a = 0;
    int frames_a = 0;
    int frames_b = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, req);
        end
    endtask

    task automatic push_a(input logic [31:0] d);
        mem_a[wr_a[5:0]] = d;
        wr_a = wr_a + 8'd1;
        exp_a.push_back({(tag_a == 3), d});
        tag_a = (tag_a + 1) % 4;
    endtask

    task automatic push_b(input logic [31:0] d);
        mem_b[wr_b[5:0]] = d;
        wr_b = wr_b + 8'd1;
        exp_b.push_back({1'b1, d});
    endtask

    // One clock: sample what will be handshaked, advance, score outputs.
    task automatic tick();
        logic va, ra, la, vb, rb, lb;
        logic [31:0] da, db;
        logic [32:0] e;
        va = ifa.m_valid; ra = ifa.m_ready; da = ifa.m_data; la = ifa.m_last;
        vb = ifb.m_valid; rb = ifb.m_ready; db = ifb.m_data; lb = ifb.m_last;
        @(posedge clock);
        @(negedge clock);
        if (va && ra) begin
            if (exp_a.size() == 0) check("a_extra_word", 64'(exp_a.size()), 64'd1);
            else begin
                e = exp_a.pop_front();
                check("a_data", 64'(da), 64'(e[31:0]));
                check("a_last", 64'(la), 64'(e[32]));
                if (e[32]) frames_a++;
            end
        end
        check("a_frame_cnt", 64'(ifa.frame_cnt), 64'(frames_a[15:0]));
        if (va && !ra) check("a_hold", 64'({ifa.m_valid, ifa.m_last, ifa.m_data}), 64'({1'b1, la, da}));
        if (vb && rb) begin
            if (exp_b.size() == 0) check("b_extra_word", 64'(exp_b.size()), 64'd1);
            else begin
                e = exp_b.pop_front();
                check("b_data", 64'(db), 64'(e[31:0]));
                check("b_last", 64'(lb), 64'(e[32]));
                if (e[32]) frames_b++;
            end
        end
        check("b_frame_cnt", 64'(ifb.frame_cnt), 64'(frames_b[1:0]));
    endtask

    initial begin
        int n_rd, n_v, first_v, last_v, base, n, nchg;
        logic [1:0] prevc;
        int seq [5];
        int wrap_exp [5];
        wrap_exp = '{1, 2, 3, 0, 1};

        reset = 1'b1;
        ifa.enable = 1'b0; ifa.m_ready = 1'b0;
        ifb.enable = 1'b0; ifb.m_ready = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_m_valid", 64'(ifa.m_valid), 64'd0);
        check("rst_m_data", 64'(ifa.m_data), 64'd0);
        check("rst_m_last", 64'(ifa.m_last), 64'd0);
        check("rst_frame_cnt", 64'(ifa.frame_cnt), 64'd0);
        check("rst_busy", 64'(ifa.busy), 64'd0);
        check("rst_rd_en", 64'(ifa.fifo_rd_en), 64'd0);
        reset = 1'b0;

        // Sustained stream
        for (int i = 0; i < 8; i++) push_a(32'h10 + 32'(i));
        tick(); tick();
        check("idle_no_pop", 64'(ifa.fifo_rd_en), 64'd0);
        ifa.enable = 1'b1; ifa.m_ready = 1'b1;
        n_rd = 0; n_v = 0; first_v = -1; last_v = -1;
        for (int i = 0; i < 14; i++) begin
            n_rd += int'(ifa.fifo_rd_en);
            tick();
            if (ifa.m_valid) begin
                n_v++;
                if (first_v < 0) first_v = i;
                last_v = i;
            end
        end
        check("stream_rd_cycles", 64'(n_rd), 64'd8);
        check("stream_valid_cycles", 64'(n_v), 64'd8);
        check("stream_contiguous", 64'(last_v - first_v), 64'd7);
        check("stream_frames", 64'(ifa.frame_cnt), 64'd2);

        // Back-pressure
        for (int i = 0; i < 8; i++) push_a(32'h20 + 32'(i));
        repeat (3) tick();
        ifa.m_ready = 1'b0;
        repeat (5) tick();
        check("bp_rd_stop", 64'(ifa.fifo_rd_en), 64'd0);
        check("bp_valid", 64'(ifa.m_valid), 64'd1);
        check("bp_head", 64'(ifa.m_data), 64'h22);
        ifa.m_ready = 1'b1;
        n = 0;
        while (exp_a.size() > 0 && n < 20) begin
            check("bp_gapfree", 64'(ifa.m_valid), 64'd1);
            tick();
            n++;
        end
        check("bp_drained", 64'(exp_a.size()), 64'd0);

        // Disable mid-frame; enable pulse during DRAIN must not matter
        base = pops_a;
        for (int i = 0; i < 5; i++) push_a(32'h30 + 32'(i));
        n = 0;
        while (pops_a < base + 2 && n < 10) begin tick(); n++; end
        check("dis_two_popped", 64'(pops_a), 64'(base + 2));
        ifa.enable = 1'b0;
        tick();
        ifa.enable = 1'b1;
        tick();
        ifa.enable = 1'b0;
        repeat (4) tick();
        check("dis_pops", 64'(pops_a), 64'(base + 4));
        check("dis_busy", 64'(ifa.busy), 64'd0);
        check("dis_rd_en", 64'(ifa.fifo_rd_en), 64'd0);
        check("dis_left", 64'(wr_a - rd_a), 64'd1);

        // FIFO underrun after the first word of a frame
        ifa.enable = 1'b1;
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("under_no_pop", 64'(ifa.fifo_rd_en), 64'd0);
        end
        check("under_busy", 64'(ifa.busy), 64'd1);
        for (int i = 0; i < 3; i++) push_a(32'h35 + 32'(i));
        repeat (6) tick();
        check("under_done", 64'(exp_a.size()), 64'd0);
        check("under_frames", 64'(ifa.frame_cnt), 64'd6);

        // Async reset with a full buffer
        for (int i = 0; i < 4; i++) push_a(32'h40 + 32'(i));
        ifa.m_ready = 1'b0;
        repeat (4) tick();
        check("pre_rst_valid", 64'(ifa.m_valid), 64'd1);
        check("pre_rst_busy", 64'(ifa.busy), 64'd1);
        #1 reset = 1'b1;
        #1;
        check("arst_valid", 64'(ifa.m_valid), 64'd0);
        check("arst_busy", 64'(ifa.busy), 64'd0);
        check("arst_frame_cnt", 64'(ifa.frame_cnt), 64'd0);
        check("arst_rd_en", 64'(ifa.fifo_rd_en), 64'd0);
        exp_a.delete(); exp_b.delete();
        tag_a = 0; frames_a = 0; frames_b = 0;
        ifa.enable = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        base = pops_a;
        for (int i = 0; i < 4; i++) push_a(32'h50 + 32'(i));
        repeat (3) tick();
        check("post_rst_no_pop", 64'(pops_a), 64'(base));
        ifa.enable = 1'b1; ifa.m_ready = 1'b1;
        repeat (8) tick();
        check("post_rst_done", 64'(exp_a.size()), 64'd0);
        check("post_rst_frames", 64'(ifa.frame_cnt), 64'd1);

        // Frame counter wrap with single-word frames
        ifb.enable = 1'b1; ifb.m_ready = 1'b1;
        for (int i = 0; i < 5; i++) push_b(32'hA0 + 32'(i));
        nchg = 0; prevc = ifb.frame_cnt;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ifb.frame_cnt != prevc) begin
                if (nchg < 5) seq[nchg] = int'(ifb.frame_cnt);
                nchg++;
                prevc = ifb.frame_cnt;
            end
        end
        check("wrap_changes", 64'(nchg), 64'd5);
        for (int i = 0; i < 5; i++) check("wrap_seq", 64'(seq[i]), 64'(wrap_exp[i]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_frame_reader.md
# fifo_frame_reader

Drain stage placed directly downstream of the team's synchronous FIFO. It pops words from the FIFO's show-ahead read port and re-emits them on a valid/ready stream, grouped into fixed-length frames marked with a last flag. A 2-entry output buffer absorbs downstream back-pressure without bubbles. A small state machine finishes any open frame cleanly when the stage is disabled.

## Interface
- DWIDTH, 32: data word width; must match the FIFO's data width.
- FRAME_LEN, 8: words per frame; legal range 1 to 2**IWIDTH.
- IWIDTH, 8: width of the in-frame word index.
- FCWIDTH, 16: width of the completed-frame counter.

- clock  in  1  rising-edge clock, shared with the FIFO.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  level; permits starting or continuing frames.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  DWIDTH  FIFO head word; valid whenever fifo_empty=0.
- fifo_rd_en  out  1  pop strobe to the FIFO; combinational.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts the word.
- m_data  out  DWIDTH  output word.
- m_last  out  1  output word is the final word of its frame.
- frame_cnt  out  FCWIDTH  count of frames fully handshaked at the output; wraps.
- busy  out  1  high when the state is not IDLE or the buffer holds data.

## Operation
- Pop rule: fifo_rd_en = (state is RUN or DRAIN) && !fifo_empty && occ<2.
  - occ is the registered buffer occupancy, 0 to 2.
  - A pop captures fifo_data into the buffer tail at the same edge.
- Each popped word carries a last tag, set when idx==FRAME_LEN-1.
  - idx increments on every pop.
  - idx returns to 0 after a pop that was tagged last.
- Buffer behaviour:
  - Strict FIFO order; the head drives m_data/m_last.
  - m_valid = (occ!=0).
  - An output handshake (m_valid && m_ready) removes the head.
  - A simultaneous push and pop leaves occ unchanged.
- frame_cnt increments, modulo 2**FCWIDTH, on every handshake where m_last=1.
- State machine (IDLE, RUN, DRAIN), reset state IDLE:
  - IDLE -> RUN when enable=1. No pops are made in IDLE.
  - RUN -> IDLE when enable=0 and idx==0 (no open frame).
  - RUN -> DRAIN when enable=0 and idx!=0.
  - RUN stays in RUN while enable=1.
  - DRAIN keeps popping regardless of enable.
  - DRAIN -> IDLE at the edge where the word tagged last is popped.
  - An IDLE entered with enable=1 re-enters RUN on the next edge.
- The FIFO guarantees stable data while empty=0 and rd_en=0. No other flow control towards the FIFO exists.

## Timing
- Reset values:
  - outputs: m_valid=0, m_data=0, m_last=0, frame_cnt=0, busy=0, fifo_rd_en=0.
  - internal: occ=0, idx=0, state=IDLE.
- Latency: a word popped at edge N appears on m_valid/m_data in the cycle after N, provided it is the buffer head.
- Throughput: 1 word/clock sustained when the FIFO is non-empty and m_ready is held at 1. occ stays at 1 in steady state.
- Back-pressure:
  - m_ready=0 lets occ rise to 2, after which popping stops.
  - m_data/m_last hold stable while m_valid=1 and m_ready=0.
- Boundary conditions:
  - FIFO empty mid-frame: popping pauses; idx and state are held; the frame resumes when data returns.
  - FRAME_LEN=1: every word is tagged last; idx stays 0.
  - frame_cnt wraps from 2**FCWIDTH-1 to 0.
  - enable toggled while in DRAIN: ignored until the frame completes.
- Reset mid-operation: all state clears immediately.
  - Words already popped but not yet handshaked are discarded.
  - The FIFO must be reset in the same cycle.

## Test plan
- Sustained stream:
  - Stimulus: FRAME_LEN=4, FIFO preloaded with 0x10..0x17, enable=1, m_ready=1.
  - Response: 8 consecutive valid cycles; m_last on 0x13 and 0x17; frame_cnt=2; fifo_rd_en high for 8 cycles.
- Back-pressure:
  - Stimulus: m_ready=0 for 5 cycles during a stream.
  - Response: occ reaches 2 and fifo_rd_en drops; the m_data head is held; the sequence resumes gap-free and in order when m_ready=1.
- Disable mid-frame:
  - Stimulus: enable drops after 2 of 4 words are popped.
  - Response: state goes to DRAIN; exactly 2 more words are popped, the second tagged last; then IDLE, busy=0 once the buffer is empty.
- FIFO underrun:
  - Stimulus: the FIFO empties after word 1 of a frame and refills 3 cycles later.
  - Response: no pops while empty; idx is held; the frame completes with m_last on its 4th word.
- Async reset:
  - Stimulus: reset asserted between clock edges with occ=2.
  - Response: m_valid and busy fall immediately; frame_cnt=0; no pops until enable after reset release.
- Counter wrap:
  - Stimulus: FCWIDTH=2, FRAME_LEN=1, 5 words streamed.
  - Response: frame_cnt sequence 1, 2, 3, 0, 1.
